// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the decode-stage fields, branch outcome and counter clear that
//   the datapath presents to the hazard controller, together with the stall,
//   flush, forwarding and counter outputs returned by the controller.
//   master : datapath side (drives D fields, PCSrcE, ClrCnt; reads controls)
//   slave  : hazard controller side
//   Parameters REG_AW / CNT_W must match those of the controller instance.
interface pipeline_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   // decode-stage metadata
   logic              ValidD;
   logic [REG_AW-1:0] Rs1D;
   logic [REG_AW-1:0] Rs2D;
   logic              UsesRs1D;
   logic              UsesRs2D;
   logic [REG_AW-1:0] RdD;
   logic              RegWriteD;
   logic              IsLoadD;
   // execute-stage branch outcome and counter control
   logic              PCSrcE;
   logic              ClrCnt;
   // controls back to the datapath
   logic              StallF;
   logic              StallD;
   logic              FlushD;
   logic              FlushE;
   logic [1:0]        ForwardAE;
   logic [1:0]        ForwardBE;
   logic [REG_AW-1:0] RdE;
   logic [CNT_W-1:0]  StallCnt;
   logic [CNT_W-1:0]  FlushCnt;

   modport master (
      output ValidD, Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, IsLoadD,
      output PCSrcE, ClrCnt,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, RdE,
      input  StallCnt, FlushCnt
   );

   modport slave (
      input  ValidD, Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, IsLoadD,
      input  PCSrcE, ClrCnt,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, RdE,
      output StallCnt, FlushCnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and forwarding controller for a 5-stage (F/D/E/M/W) RISC-V core.
//   Keeps a shadow copy of E/M/W instruction metadata, advanced in lockstep
//   with the datapath, and derives stall, flush and forwarding selects from
//   it. Also keeps saturating stall/flush cycle counters.
// Ports:
//   clk   : core clock
//   reset : synchronous, active-low reset
//   hz    : pipeline_hazard_ctrl_if.slave
//           in : ValidD Rs1D Rs2D UsesRs1D UsesRs2D RdD RegWriteD IsLoadD
//                PCSrcE ClrCnt
//           out: StallF StallD FlushD FlushE ForwardAE ForwardBE RdE
//                StallCnt FlushCnt
// Parameters:
//   REG_AW : register index width
//   FWD_EN : 1 = forward from M/W, stall on load-use only;
//            0 = no forwarding, stall until the producer reaches W
//   CNT_W  : width of each performance counter
module pipeline_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter bit FWD_EN = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   pipeline_hazard_ctrl_if.slave   hz
);

   typedef struct packed {
      logic              valid;
      logic              regwrite;
      logic              isload;
      logic              usesrs1;
      logic              usesrs2;
      logic [REG_AW-1:0] rd;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } stage_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // A stage "writes r" only for a live, register-writing instruction and
   // never for x0, so x0 can never cause a hazard or a forward.
   function automatic logic writes(input stage_t s, input logic [REG_AW-1:0] r);
      return s.valid && s.regwrite && (s.rd == r) && (r != '0);
   endfunction

   stage_t           stage_d;
   stage_t           stage_e_reg;
   stage_t           stage_m_reg;
   stage_t           stage_w_reg;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic [CNT_W-1:0] flush_cnt_reg;

   logic use1_d;
   logic use2_d;
   logic e_hits_d;
   logic m_hits_d;
   logic hazard;
   logic stall;
   logic flush_d;
   logic flush_e;

   // Only the destination side of M/W feeds logic; the remaining metadata is
   // carried so the shadow stages mirror the datapath registers exactly.
   logic shadow_unused;
   assign shadow_unused = ^{stage_m_reg, stage_w_reg};

   always_comb begin
      stage_d          = '0;
      stage_d.valid    = hz.ValidD;
      stage_d.regwrite = hz.RegWriteD;
      stage_d.isload   = hz.IsLoadD;
      stage_d.usesrs1  = hz.UsesRs1D;
      stage_d.usesrs2  = hz.UsesRs2D;
      stage_d.rd       = hz.RdD;
      stage_d.rs1      = hz.Rs1D;
      stage_d.rs2      = hz.Rs2D;
   end

   // ---------------- hazard detection ----------------
   assign use1_d   = hz.ValidD & hz.UsesRs1D;
   assign use2_d   = hz.ValidD & hz.UsesRs2D;
   assign e_hits_d = (use1_d & writes(stage_e_reg, hz.Rs1D)) |
                     (use2_d & writes(stage_e_reg, hz.Rs2D));
   assign m_hits_d = (use1_d & writes(stage_m_reg, hz.Rs1D)) |
                     (use2_d & writes(stage_m_reg, hz.Rs2D));

   // Without forwarding, W is still safe because the regfile is write-first.
   assign hazard = FWD_EN ? (stage_e_reg.isload & e_hits_d)
                          : (e_hits_d | m_hits_d);

   // A taken branch outranks a hazard: the stalled instruction in D is on
   // the wrong path anyway, so it is flushed instead of held.
   always_comb begin
      stall   = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (!reset) begin
         flush_e = 1'b1;
      end else if (hz.PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (hazard) begin
         stall   = 1'b1;
         flush_e = 1'b1;
      end
   end

   assign hz.StallF = stall;
   assign hz.StallD = stall;
   assign hz.FlushD = flush_d;
   assign hz.FlushE = flush_e;
   assign hz.RdE    = stage_e_reg.rd;

   // ---------------- forwarding selects ----------------
   // Index 0 is operand A (rs1), index 1 is operand B (rs2). M is checked
   // first because it holds the younger, more recent value.
   logic [1:0][REG_AW-1:0] e_src;
   logic [1:0]             e_uses;
   logic [1:0][1:0]        fwd_sel;

   assign e_src[0]  = stage_e_reg.rs1;
   assign e_src[1]  = stage_e_reg.rs2;
   assign e_uses[0] = stage_e_reg.usesrs1;
   assign e_uses[1] = stage_e_reg.usesrs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign fwd_sel[gi] =
            (!FWD_EN || !reset || !e_uses[gi])  ? 2'b00 :
            writes(stage_m_reg, e_src[gi])      ? 2'b10 :
            writes(stage_w_reg, e_src[gi])      ? 2'b01 : 2'b00;
      end
   endgenerate

   assign hz.ForwardAE = fwd_sel[0];
   assign hz.ForwardBE = fwd_sel[1];

   // ---------------- shadow pipeline ----------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_e_reg <= '0;
         stage_m_reg <= '0;
         stage_w_reg <= '0;
      end else begin
         stage_w_reg <= stage_m_reg;
         stage_m_reg <= stage_e_reg;
         stage_e_reg <= flush_e ? '0 : stage_d;
      end
   end

   // ---------------- performance counters ----------------
   always_ff @(posedge clk) begin
      if (!reset || hz.ClrCnt) begin
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         if (stall && (stall_cnt_reg != CNT_MAX))
            stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
         if (hz.PCSrcE && (flush_cnt_reg != CNT_MAX))
            flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
      end
   end

   assign hz.StallCnt = stall_cnt_reg;
   assign hz.FlushCnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed bench. Three controllers share one stimulus stream:
//     u1 : FWD_EN=1, CNT_W=16
//     u0 : FWD_EN=0, CNT_W=16
//     u2 : FWD_EN=0, CNT_W=2 (counter saturation, reset mid-stall, clear)
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   checked one unit later, well away from the next edge.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       valid_d, use1_d, use2_d, rw_d, ld_d, pcsrc_e, clr_cnt;
   logic [4:0] rs1_d, rs2_d, rd_d;

   int total = 0;
   int bad   = 0;

   pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if1 ();
   pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if0 ();
   pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(2))  if2 ();

   assign if1.ValidD = valid_d;  assign if0.ValidD = valid_d;  assign if2.ValidD = valid_d;
   assign if1.Rs1D = rs1_d;      assign if0.Rs1D = rs1_d;      assign if2.Rs1D = rs1_d;
   assign if1.Rs2D = rs2_d;      assign if0.Rs2D = rs2_d;      assign if2.Rs2D = rs2_d;
   assign if1.UsesRs1D = use1_d; assign if0.UsesRs1D = use1_d; assign if2.UsesRs1D = use1_d;
   assign if1.UsesRs2D = use2_d; assign if0.UsesRs2D = use2_d; assign if2.UsesRs2D = use2_d;
   assign if1.RdD = rd_d;        assign if0.RdD = rd_d;        assign if2.RdD = rd_d;
   assign if1.RegWriteD = rw_d;  assign if0.RegWriteD = rw_d;  assign if2.RegWriteD = rw_d;
   assign if1.IsLoadD = ld_d;    assign if0.IsLoadD = ld_d;    assign if2.IsLoadD = ld_d;
   assign if1.PCSrcE = pcsrc_e;  assign if0.PCSrcE = pcsrc_e;  assign if2.PCSrcE = pcsrc_e;
   assign if1.ClrCnt = clr_cnt;  assign if0.ClrCnt = clr_cnt;  assign if2.ClrCnt = clr_cnt;

   pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) u1 (
      .clk(clk), .reset(reset), .hz(if1));
   pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(16)) u0 (
      .clk(clk), .reset(reset), .hz(if0));
   pipeline_hazard_ctrl #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(2)) u2 (
      .clk(clk), .reset(reset), .hz(if2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one D-stage instruction and let the combinational outputs settle.
   task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic rw, input logic ld);
      valid_d = v; rs1_d = r1; use1_d = u1; rs2_d = r2; use2_d = u2;
      rd_d = rd; rw_d = rw; ld_d = ld;
      #1;
   endtask

   task automatic nop();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0; pcsrc_e = 1'b0; clr_cnt = 1'b0;
      nop();
      tick();
      reset = 1'b1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      reset = 1'b0; pcsrc_e = 1'b0; clr_cnt = 1'b0;
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1);
      tick(); tick();
      pcsrc_e = 1'b1;
      #1;
      chk("rst_stallf",   if1.StallF,    0);
      chk("rst_stalld",   if1.StallD,    0);
      chk("rst_flushd",   if1.FlushD,    0);
      chk("rst_flushe",   if1.FlushE,    1);
      chk("rst_fwda",     if1.ForwardAE, 0);
      chk("rst_rde",      if1.RdE,       0);
      chk("rst_stallcnt", if1.StallCnt,  0);
      tick();
      chk("rst_flushcnt", if1.FlushCnt,  0);
      reset = 1'b1; pcsrc_e = 1'b0;
      nop();
      chk("rel_stalld",   if1.StallD,    0);
      chk("rel_flushe",   if1.FlushE,    0);

      // ---------------- load-use, forwarding on ----------------
      do_reset();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
      chk("lu_lw_nostall", if1.StallD, 0);
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
      chk("lu_stallf", if1.StallF, 1);
      chk("lu_stalld", if1.StallD, 1);
      chk("lu_flushe", if1.FlushE, 1);
      chk("lu_flushd", if1.FlushD, 0);
      chk("lu_rde_lw", if1.RdE,    5);
      tick();
      chk("lu_release", if1.StallD,   0);
      chk("lu_cnt",     if1.StallCnt, 1);
      tick();
      nop();
      chk("lu_fwda_w",  if1.ForwardAE, 1);
      chk("lu_fwdb",    if1.ForwardBE, 0);
      chk("lu_rde_add", if1.RdE,       6);
      chk("lu_cnt_end", if1.StallCnt,  1);

      // ---------------- ALU-to-ALU, forwarding on ----------------
      do_reset();
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // sub x7,x5,x5
      chk("aa_nostall",    if1.StallD, 0);
      chk("aa_nofwd_stall", if0.StallD, 1);
      tick();
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      chk("aa_fwda_m", if1.ForwardAE, 2);
      chk("aa_fwdb_m", if1.ForwardBE, 2);
      tick();
      nop();
      chk("aa_fwda_none", if1.ForwardAE, 0);
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // sub x7,x5,x5
      chk("gap_nostall", if1.StallD, 0);
      tick();
      nop();
      chk("gap_fwda_w", if1.ForwardAE, 1);
      chk("gap_fwdb_w", if1.ForwardBE, 1);
      chk("aa_cnt",     if1.StallCnt,  0);

      // ---------------- x0 never hazards or forwards ----------------
      do_reset();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x1,1
      tick();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x0,x0
      chk("x0_stall_fwd",   if1.StallD, 0);
      chk("x0_stall_nofwd", if0.StallD, 0);
      tick();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0,0(x1)
      chk("x0_fwda_m", if1.ForwardAE, 0);
      chk("x0_fwdb_m", if1.ForwardBE, 0);
      tick();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x0,x0
      chk("x0_lw_stall", if1.StallD, 0);
      tick();
      nop();
      chk("x0_lw_fwda", if1.ForwardAE, 0);
      chk("x0_lw_fwdb", if1.ForwardBE, 0);
      chk("x0_cnt",     if1.StallCnt,  0);

      // ---------------- no forwarding: back-to-back dependency ----------------
      do_reset();
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
      chk("nf_stall1", if0.StallD,    1);
      chk("nf_fwda1",  if0.ForwardAE, 0);
      tick();
      chk("nf_stall2", if0.StallD,    1);
      tick();
      chk("nf_stall3", if0.StallD,    0);
      tick();
      nop();
      chk("nf_fwda",  if0.ForwardAE, 0);
      chk("nf_fwdb",  if0.ForwardBE, 0);
      chk("nf_rde",   if0.RdE,       6);
      chk("nf_cnt",   if0.StallCnt,  2);

      // ---------------- branch together with load-use ----------------
      do_reset();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
      tick();
      pcsrc_e = 1'b1;
      drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
      chk("br_flushd", if1.FlushD, 1);
      chk("br_flushe", if1.FlushE, 1);
      chk("br_stalld", if1.StallD, 0);
      chk("br_stallf", if1.StallF, 0);
      tick();
      pcsrc_e = 1'b0;
      nop();
      chk("br_flushcnt", if1.FlushCnt, 1);
      chk("br_stallcnt", if1.StallCnt, 0);
      chk("br_rde",      if1.RdE,      0);

      // ---------------- 2-bit counter: saturation, reset mid-stall, clear ----
      do_reset();
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
      chk("sat_stall_a", if2.StallD, 1);
      tick(); tick();
      chk("sat_cnt2", if2.StallCnt, 2);
      tick();
      drive(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);   // add x7,x6,x6
      chk("sat_stall_b", if2.StallD, 1);
      tick(); tick();
      chk("sat_cnt3", if2.StallCnt, 3);
      tick();
      drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);   // add x8,x7,x0
      chk("sat_stall_c", if2.StallD, 1);
      tick();
      chk("sat_stall_d", if2.StallD,   1);
      chk("sat_hold3",   if2.StallCnt, 3);
      reset = 1'b0;
      #1;
      chk("mid_rst_stalld", if2.StallD, 0);
      chk("mid_rst_flushe", if2.FlushE, 1);
      tick();
      reset = 1'b1;
      nop();
      chk("mid_rst_cnt",   if2.StallCnt, 0);
      chk("mid_rst_after", if2.StallD,   0);
      drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      tick();
      drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x5
      tick();
      chk("clr_pre_cnt", if2.StallCnt, 1);
      clr_cnt = 1'b1;
      #1;
      chk("clr_stalld", if2.StallD, 1);
      tick();
      clr_cnt = 1'b0;
      #1;
      chk("clr_cnt", if2.StallCnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
